// File: rtl/eth_xcvr_link_ctrl_pkg.sv
// Shared types and elaboration helpers for the transceiver link sequencer.
// The ETH_XCVR_LINK_CTRL_STATS_EN statistics option lives in the top module.
package eth_xcvr_link_ctrl_pkg;

    typedef enum logic [2:0] {
        StResetAll = 3'd0,
        StWaitPwr  = 3'd1,
        StWaitPll  = 3'd2,
        StWaitDone = 3'd3,
        StWaitLock = 3'd4,
        StLinkUp   = 3'd5,
        StRxReset  = 3'd6
    } link_state_e;

    // Width of retry_count: enough bits to hold 0..max_retries.
    function automatic int unsigned retry_width(input int unsigned max_retries);
        return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
    endfunction

    localparam int unsigned RETRY_W_DEFAULT = retry_width(4);

    // True when a timer of 'width' bits can count 0..value-1.
    function automatic bit cnt_fits(input int unsigned value, input int unsigned width);
        if (value == 0) return 1'b0;
        if (width >= 32) return 1'b1;
        return value <= (32'd1 << width);
    endfunction

endpackage

// File: rtl/eth_xcvr_link_ctrl_sync_signal.sv
// Two-flop synchronizer for a bundle of independent asynchronous status bits.
// No reset on the data path; the consumer tolerates two cycles of unknown history.
module sync_signal #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        r_meta <= i_data;
        r_sync <= r_meta;
    end

    assign o_data = r_sync;

endmodule

// File: rtl/eth_xcvr_link_ctrl.sv
// Bring-up / recovery sequencer for one GT lane and its 64b/66b PHY.
// Define ETH_XCVR_LINK_CTRL_STATS_EN to add the link-down / full-reset counters.
module eth_xcvr_link_ctrl
    import eth_xcvr_link_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES    = 16,
    parameter int unsigned PLL_TIMEOUT     = 65536,
    parameter int unsigned DONE_TIMEOUT    = 65536,
    parameter int unsigned LOCK_TIMEOUT    = 262144,
    parameter int unsigned BER_HOLD        = 1024,
    parameter int unsigned RX_RESET_CYCLES = 8,
    parameter int unsigned MAX_RETRIES     = 4,
    parameter int unsigned CNT_WIDTH       = 20
) (
    input  logic                                xcvr_ctrl_clk,
    input  logic                                xcvr_ctrl_rst_n,
    input  logic                                gtpowergood,
    input  logic                                qpll0lock,
    input  logic                                gt_reset_tx_done,
    input  logic                                gt_reset_rx_done,
    input  logic                                phy_rx_block_lock,
    input  logic                                phy_rx_high_ber,
    input  logic                                force_reset,
    output logic                                gt_reset_all,
    output logic                                gt_reset_rx_datapath,
    output logic                                link_up,
    output logic [2:0]                          state,
    output logic [retry_width(MAX_RETRIES)-1:0] retry_count
`ifdef ETH_XCVR_LINK_CTRL_STATS_EN
    ,
    output logic [15:0]                         stat_link_down,
    output logic [15:0]                         stat_full_reset
`endif
);

    localparam int unsigned RetryW = retry_width(MAX_RETRIES);

    localparam logic [CNT_WIDTH-1:0] ResetLast = CNT_WIDTH'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] PllLast   = CNT_WIDTH'(PLL_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] DoneLast  = CNT_WIDTH'(DONE_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] LockLast  = CNT_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] BerLast   = CNT_WIDTH'(BER_HOLD - 1);
    localparam logic [CNT_WIDTH-1:0] RxLast    = CNT_WIDTH'(RX_RESET_CYCLES - 1);
    localparam logic [RetryW-1:0]    RetryMax  = RetryW'(MAX_RETRIES);

    if (!cnt_fits(RESET_CYCLES, CNT_WIDTH) || !cnt_fits(PLL_TIMEOUT, CNT_WIDTH) ||
        !cnt_fits(DONE_TIMEOUT, CNT_WIDTH) || !cnt_fits(LOCK_TIMEOUT, CNT_WIDTH) ||
        !cnt_fits(BER_HOLD, CNT_WIDTH) || !cnt_fits(RX_RESET_CYCLES, CNT_WIDTH) ||
        MAX_RETRIES < 1) begin : g_bad_config
        $error("eth_xcvr_link_ctrl: CNT_WIDTH too small or a timing parameter is zero");
    end

    logic [5:0] w_sync;
    logic       w_pgood, w_plock, w_tx_done, w_rx_done, w_lock, w_high_ber;
    logic       w_pwr_ok, w_phy_good;

    sync_signal #(
        .WIDTH (6)
    ) u_sync (
        .i_clk  (xcvr_ctrl_clk),
        .i_data ({gtpowergood, qpll0lock, gt_reset_tx_done, gt_reset_rx_done,
                  phy_rx_block_lock, phy_rx_high_ber}),
        .o_data (w_sync)
    );

    assign {w_pgood, w_plock, w_tx_done, w_rx_done, w_lock, w_high_ber} = w_sync;
    assign w_pwr_ok   = w_pgood & w_plock;
    assign w_phy_good = w_lock & ~w_high_ber;

    link_state_e          r_state, w_state_d;
    logic [CNT_WIDTH-1:0] r_tmr, w_tmr_d;
    logic [RetryW-1:0]    r_retry, w_retry_d;
    logic                 r_rst_all, r_rst_rx, r_link_up;
    logic                 w_restart, w_rst_rx_d;

    always_comb begin
        w_state_d  = r_state;
        w_tmr_d    = r_tmr + 1'b1;
        w_retry_d  = r_retry;
        w_restart  = 1'b0;
        w_rst_rx_d = 1'b0;

        if (force_reset) begin
            w_state_d = StResetAll;
            w_restart = 1'b1;
        end else begin
            case (r_state)
                StResetAll: begin
                    if (r_tmr == ResetLast) begin
                        w_state_d = StWaitPwr;
                        w_retry_d = '0;
                    end
                end
                StWaitPwr: if (w_pgood) w_state_d = StWaitPll;
                StWaitPll: begin
                    if (w_plock)               w_state_d = StWaitDone;
                    else if (r_tmr == PllLast) w_state_d = StResetAll;
                end
                StWaitDone: begin
                    if (!w_pwr_ok)                   w_state_d = StResetAll;
                    else if (w_tx_done && w_rx_done) w_state_d = StWaitLock;
                    else if (r_tmr == DoneLast)      w_state_d = StResetAll;
                end
                StWaitLock: begin
                    if (!w_pwr_ok)              w_state_d = StResetAll;
                    else if (w_phy_good)        w_state_d = StLinkUp;
                    else if (r_tmr == LockLast) w_state_d = StRxReset;
                end
                StLinkUp: begin
                    // Timer here counts consecutive bad cycles only.
                    if (!w_pwr_ok)             w_state_d = StResetAll;
                    else if (w_phy_good)       w_tmr_d   = '0;
                    else if (r_tmr == BerLast) w_state_d = StRxReset;
                end
                StRxReset: begin
                    // A pulse-less RX_RESET means retries are exhausted.
                    if (!r_rst_rx)            w_state_d = StResetAll;
                    else if (r_tmr == RxLast) w_state_d = StWaitDone;
                end
                default: w_state_d = StResetAll;
            endcase
        end

        if (w_state_d != r_state) w_restart = 1'b1;
        if (w_restart)            w_tmr_d   = '0;

        if (w_state_d == StRxReset) begin
            if (r_state == StRxReset) begin
                w_rst_rx_d = r_rst_rx;
            end else begin
                w_rst_rx_d = (r_retry != RetryMax);
                if (r_retry != RetryMax) w_retry_d = r_retry + 1'b1;
            end
        end
    end

    always_ff @(posedge xcvr_ctrl_clk or negedge xcvr_ctrl_rst_n) begin
        if (!xcvr_ctrl_rst_n) begin
            r_state   <= StResetAll;
            r_tmr     <= '0;
            r_retry   <= '0;
            r_rst_all <= 1'b1;
            r_rst_rx  <= 1'b0;
            r_link_up <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_tmr     <= w_tmr_d;
            r_retry   <= w_retry_d;
            r_rst_all <= (w_state_d == StResetAll);
            r_rst_rx  <= w_rst_rx_d;
            r_link_up <= (w_state_d == StLinkUp);
        end
    end

    assign gt_reset_all         = r_rst_all;
    assign gt_reset_rx_datapath = r_rst_rx;
    assign link_up              = r_link_up;
    assign state                = r_state;
    assign retry_count          = r_retry;

`ifdef ETH_XCVR_LINK_CTRL_STATS_EN
    logic [15:0] r_stat_link_down, r_stat_full_reset;
    logic        w_link_exit, w_full_entry;

    assign w_link_exit  = (r_state == StLinkUp) && (w_state_d != StLinkUp);
    assign w_full_entry = (w_state_d == StResetAll) && w_restart;

    always_ff @(posedge xcvr_ctrl_clk or negedge xcvr_ctrl_rst_n) begin
        if (!xcvr_ctrl_rst_n) begin
            r_stat_link_down  <= '0;
            r_stat_full_reset <= '0;
        end else begin
            if (w_link_exit && r_stat_link_down != 16'hffff)
                r_stat_link_down <= r_stat_link_down + 1'b1;
            if (w_full_entry && r_stat_full_reset != 16'hffff)
                r_stat_full_reset <= r_stat_full_reset + 1'b1;
        end
    end

    assign stat_link_down  = r_stat_link_down;
    assign stat_full_reset = r_stat_full_reset;
`endif

endmodule
